// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined subtractor: D = A - B - borrow, computed as A + ~B + !borrow
// with 4-bit carry-lookahead blocks; low half in stage 1, high half in stage 2.
module cla_subtractor_pipe #(
    parameter int unsigned BIT = 32
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [BIT-1:0] i_data_a,
    input  logic [BIT-1:0] i_data_b,
    input  logic           i_borrow,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [BIT-1:0] o_data_d,
    output logic           o_borrow,
    output logic           o_overflow,
    output logic           o_zero
);

    localparam int unsigned HALF = BIT / 2;
    localparam int unsigned NBLK = HALF / 4;

    // One 4-bit lookahead block; returns {carry_out, sum}.
    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                        input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a | b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], a ^ b ^ c[3:0]};
    endfunction

    // Half-width adder from rippled CLA blocks; returns {carry_out, sum}.
    function automatic logic [HALF:0] add_half(input logic [HALF-1:0] a,
                                               input logic [HALF-1:0] b,
                                               input logic ci);
        logic [HALF-1:0] s;
        logic            c;
        logic [4:0]      r;
        s = '0;
        c = ci;
        for (int unsigned k = 0; k < NBLK; k++) begin
            r            = cla4(a[4*k +: 4], b[4*k +: 4], c);
            s[4*k +: 4]  = r[3:0];
            c            = r[4];
        end
        return {c, s};
    endfunction

    // Handshake
    logic out_valid_q, out_valid_d;
    logic s1_valid_q,  s1_valid_d;
    logic out_adv, s1_adv;

    assign out_adv = !out_valid_q || i_ready;
    assign s1_adv  = !s1_valid_q || out_adv;
    assign o_ready = s1_adv;
    assign o_valid = out_valid_q;

    // Stage 1: low-half add
    logic [HALF-1:0] s1_dlo_q,   s1_dlo_d;
    logic            s1_c_q,     s1_c_d;
    logic [HALF-1:0] s1_a_hi_q,  s1_a_hi_d;
    logic [HALF-1:0] s1_nb_hi_q, s1_nb_hi_d;
    logic            s1_a_msb_q, s1_a_msb_d;
    logic            s1_b_msb_q, s1_b_msb_d;
    logic [HALF:0]   lo_sum;

    assign lo_sum = add_half(i_data_a[HALF-1:0], ~i_data_b[HALF-1:0], ~i_borrow);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_dlo_d    = s1_dlo_q;
        s1_c_d      = s1_c_q;
        s1_a_hi_d   = s1_a_hi_q;
        s1_nb_hi_d  = s1_nb_hi_q;
        s1_a_msb_d  = s1_a_msb_q;
        s1_b_msb_d  = s1_b_msb_q;
        if (s1_adv) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                s1_dlo_d   = lo_sum[HALF-1:0];
                s1_c_d     = lo_sum[HALF];
                s1_a_hi_d  = i_data_a[BIT-1:HALF];
                s1_nb_hi_d = ~i_data_b[BIT-1:HALF];
                s1_a_msb_d = i_data_a[BIT-1];
                s1_b_msb_d = i_data_b[BIT-1];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_valid_q  <= 1'b0;
            s1_dlo_q    <= '0;
            s1_c_q      <= 1'b0;
            s1_a_hi_q   <= '0;
            s1_nb_hi_q  <= '0;
            s1_a_msb_q  <= 1'b0;
            s1_b_msb_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_dlo_q    <= s1_dlo_d;
            s1_c_q      <= s1_c_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_nb_hi_q  <= s1_nb_hi_d;
            s1_a_msb_q  <= s1_a_msb_d;
            s1_b_msb_q  <= s1_b_msb_d;
        end
    end

    // Stage 2: high-half add and output register
    logic [HALF:0]  hi_sum;
    logic [BIT-1:0] diff;
    logic [BIT-1:0] d_q, d_d;
    logic           borrow_q, borrow_d;
    logic           ovf_q, ovf_d;
    logic           zero_q, zero_d;

    assign hi_sum = add_half(s1_a_hi_q, s1_nb_hi_q, s1_c_q);
    assign diff   = {hi_sum[HALF-1:0], s1_dlo_q};

    always_comb begin
        out_valid_d = out_valid_q;
        d_d         = d_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (out_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                d_d      = diff;
                borrow_d = ~hi_sum[HALF];
                ovf_d    = (s1_a_msb_q != s1_b_msb_q) && (diff[BIT-1] != s1_a_msb_q);
                zero_d   = (diff == '0);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign o_data_d   = d_q;
    assign o_borrow   = borrow_q;
    assign o_overflow = ovf_q;
    assign o_zero     = zero_q;

endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Bench for cla_subtractor_pipe: directed spec vectors, backpressure, mid-stream reset,
// then randomized traffic scored against an arithmetic reference model.
module tb_cla_subtractor_pipe;

    localparam int unsigned BIT = 32;

    logic           clk = 1'b0;
    logic           rstn;
    logic           i_valid, i_ready, i_borrow;
    logic [BIT-1:0] i_data_a, i_data_b;
    logic           o_ready, o_valid, o_borrow, o_overflow, o_zero;
    logic [BIT-1:0] o_data_d;

    cla_subtractor_pipe #(.BIT(BIT)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_a   (i_data_a),
        .i_data_b   (i_data_b),
        .i_borrow   (i_borrow),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data_d   (o_data_d),
        .o_borrow   (o_borrow),
        .o_overflow (o_overflow),
        .o_zero     (o_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [BIT-1:0] d;
        logic           b;
        logic           o;
        logic           z;
    } res_t;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    res_t        sb[$];
    logic        held = 1'b0;
    res_t        held_val;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, unsigned for borrow, signed for overflow.
    function automatic res_t model(input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                                   input logic bor);
        res_t         r;
        logic [BIT:0] full;
        longint       sa, sbv, dv, lim;
        full = {1'b0, a} - {1'b0, b} - {{BIT{1'b0}}, bor};
        r.d  = full[BIT-1:0];
        r.b  = full[BIT];
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        dv   = sa - sbv - longint'(bor);
        lim  = longint'(1) <<< (BIT - 1);
        r.o  = (dv >= lim) || (dv < -lim);
        r.z  = (r.d == '0);
        return r;
    endfunction

    function automatic logic [BIT-1:0] pick();
        logic [BIT-1:0] v;
        case ($urandom % 8)
            0:       v = '0;
            1:       v = 1;
            2:       v = '1;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7fff_ffff;
            5:       v = 32'h0001_0000;
            6:       v = 32'h0000_ffff;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Scoreboard monitor, sampled mid-cycle for the transfers at the next rising edge.
    always @(negedge clk) begin
        res_t cur;
        res_t exp;
        if (rstn) begin
            cur = {o_data_d, o_borrow, o_overflow, o_zero};
            check_eq("o_ready", 64'(o_ready), 64'((sb.size() < 2) || i_ready));
            if (held)
                check_eq("hold", 64'({o_valid, cur}), 64'({1'b1, held_val}));
            held     = o_valid && !i_ready;
            held_val = cur;
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check_eq("out_unexpected", 64'(o_valid), 64'(0));
                end else begin
                    exp = sb.pop_front();
                    check_eq("result", 64'(cur), 64'(exp));
                end
            end
            if (i_valid && o_ready)
                sb.push_back(model(i_data_a, i_data_b, i_borrow));
        end else begin
            held = 1'b0;
        end
    end

    task automatic one_shot(input string tag, input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                            input logic bor, input logic [BIT-1:0] ed,
                            input logic eb, input logic eo, input logic ez);
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_data_a = a;
        i_data_b = b;
        i_borrow = bor;
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, 64'(o_valid), 64'(1));
        check_eq({tag, "_d"}, 64'(o_data_d), 64'(ed));
        check_eq({tag, "_flags"}, 64'({o_borrow, o_overflow, o_zero}), 64'({eb, eo, ez}));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int unsigned     idx;
        int unsigned     got_n;
        logic [BIT-1:0]  got_d[4];
        int unsigned     got_cyc[4];
        logic [BIT-1:0]  last_d;

        rstn     = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_borrow = 1'b0;
        i_data_a = '0;
        i_data_b = '0;
        #1;
        check_eq("rst_state", 64'({o_valid, o_data_d, o_borrow, o_overflow, o_zero}), 64'(0));
        check_eq("rst_ready", 64'(o_ready), 64'(1));
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk); #1;

        one_shot("basic",   32'd5,          32'd3, 1'b0, 32'd2,          1'b0, 1'b0, 1'b0);
        one_shot("under",   32'd0,          32'd1, 1'b0, 32'hffff_ffff,  1'b1, 1'b0, 1'b0);
        one_shot("equal",   32'd7,          32'd7, 1'b0, 32'd0,          1'b0, 1'b0, 1'b1);
        one_shot("sovf",    32'h8000_0000,  32'd1, 1'b0, 32'h7fff_ffff,  1'b0, 1'b1, 1'b0);
        one_shot("bin",     32'd0,          32'd0, 1'b1, 32'hffff_ffff,  1'b1, 1'b0, 1'b0);
        one_shot("xhalf",   32'h0001_0000,  32'd1, 1'b0, 32'h0000_ffff,  1'b0, 1'b0, 1'b0);

        // Backpressure: four inputs against a stalled sink.
        i_ready  = 1'b0;
        i_borrow = 1'b0;
        idx      = 0;
        for (int c = 0; c < 6; c++) begin
            i_valid  = 1'b1;
            i_data_a = BIT'(idx + 1);
            i_data_b = 1;
            @(negedge clk);
            if (o_ready) idx++;
            @(posedge clk); #1;
        end
        check_eq("bp_accepts", 64'(idx), 64'(2));
        check_eq("bp_ready",   64'(o_ready), 64'(0));
        check_eq("bp_hold_d",  64'({o_valid, o_data_d}), 64'({1'b1, 32'd0}));
        i_data_a = BIT'(idx + 1);
        i_ready  = 1'b1;
        got_n    = 0;
        for (int c = 0; c < 12 && got_n < 4; c++) begin
            @(negedge clk);
            if (o_valid && i_ready) begin
                got_d[got_n]   = o_data_d;
                got_cyc[got_n] = c;
                got_n++;
            end
            if (i_valid && o_ready) idx++;
            @(posedge clk); #1;
            if (idx < 4) begin
                i_data_a = BIT'(idx + 1);
            end else begin
                i_valid = 1'b0;
            end
        end
        check_eq("bp_count", 64'(got_n), 64'(4));
        for (int unsigned k = 0; k < 4 && k < got_n; k++) begin
            check_eq("bp_order", 64'(got_d[k]), 64'(k));
            check_eq("bp_rate",  64'(got_cyc[k]), 64'(got_cyc[0] + k));
        end
        repeat (3) @(posedge clk);
        #1;

        // Reset while both stages hold data.
        i_ready  = 1'b0;
        i_valid  = 1'b1;
        i_data_a = 32'd20;
        i_data_b = 32'd1;
        @(posedge clk); #1;
        i_data_a = 32'd30;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check_eq("mid_full", 64'({o_valid, o_ready}), 64'({1'b1, 1'b0}));
        #2 rstn = 1'b0;
        sb.delete();
        #1;
        check_eq("mid_rst_out", 64'({o_valid, o_data_d, o_borrow, o_overflow, o_zero}), 64'(0));
        check_eq("mid_rst_ready", 64'(o_ready), 64'(1));
        @(negedge clk);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        i_ready  = 1'b1;
        i_valid  = 1'b1;
        i_data_a = 32'd9;
        i_data_b = 32'd4;
        @(posedge clk); #1;
        i_valid = 1'b0;
        got_n   = 0;
        last_d  = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_valid && i_ready) begin
                got_n++;
                last_d = o_data_d;
            end
        end
        check_eq("post_rst_count", 64'(got_n), 64'(1));
        check_eq("post_rst_d",     64'(last_d), 64'(5));
        @(posedge clk); #1;

        // Randomized traffic with alternating backpressure intensity.
        for (int c = 0; c < 3000; c++) begin
            i_valid  = ($urandom % 4) != 0;
            i_data_a = pick();
            i_data_b = pick();
            i_borrow = $urandom % 2;
            if ((c / 200) % 2 == 0) i_ready = ($urandom % 4) != 0;
            else                    i_ready = ($urandom % 3) == 0;
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        check_eq("drain", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
